// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared constants and types for the MIPS pipeline control logic:
//   FSM state encoding, register-field width and the register-zero
//   constant, plus the load-use hazard compare used by if_hazard_ctrl.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } pipe_state_t;

    // A load in EX writing a non-zero register that the ID instruction reads.
    // $zero is never a real producer, so it can never cause a stall.
    function automatic logic load_use_hz(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
//   Saturating up-counter: increments while i_inc is high and holds at
//   all-ones instead of wrapping.
// Ports:
//   i_clk  clock (rising edge)
//   i_rst  asynchronous active-high reset, clears the count
//   i_inc  increment enable
//   o_cnt  current count
module hazard_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc && !w_sat)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_hazard_ctrl.sv
// if_hazard_ctrl
//   IF-stage / pipeline-register sequencer for the MIPS core. Detects
//   load-use hazards and holds PC and IF/ID for LOAD_STALL cycles while
//   bubbling ID/EX; resolves taken branches from MEM by selecting the
//   branch target and flushing IF/ID, ID/EX and EX/MEM.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds STALL_CNT / FLUSH_CNT).
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   ID_RS, ID_RT          source fields of the ID instruction
//   ID_USES_RT            ID instruction reads rt
//   EX_MEM_READ, EX_RT    load in EX and its destination register
//   BRANCH_TAKEN          branch resolved taken in MEM
//   PC_WRITE, IF_ID_WRITE load enables
//   IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  bubble inserts
//   PC_SRC                0 = PC+4, 1 = branch target
//   STATE                 registered FSM state (0 RUN, 1 STALL)
//   STALL_CNT, FLUSH_CNT  saturating perf counters (macro only)
module if_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] ID_RS,
    input  logic [REG_W-1:0] ID_RT,
    input  logic             ID_USES_RT,
    input  logic             EX_MEM_READ,
    input  logic [REG_W-1:0] EX_RT,
    input  logic             BRANCH_TAKEN,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic             PC_SRC,
    output logic             STATE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

    // Cycles still to stall after the first one.
    localparam logic [3:0] STALL_EXTRA = 4'(LOAD_STALL - 1);

    pipe_state_t r_state, w_state_nxt;
    logic [3:0]  r_rem, w_rem_nxt;
    logic        w_hz;

    assign w_hz = load_use_hz(EX_MEM_READ, EX_RT, ID_RS, ID_RT, ID_USES_RT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
            r_rem   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        PC_SRC       = 1'b0;
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;

        if (RST) begin
            // Outputs follow reset combinationally so the pipeline is
            // frozen and bubbled the instant RST rises.
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
            w_state_nxt  = ST_RUN;
            w_rem_nxt    = 4'd0;
        end else if (BRANCH_TAKEN) begin
            // Branch beats any stall: the stalled instructions are on the
            // wrong path and get squashed anyway.
            PC_SRC       = 1'b1;
            IF_ID_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
            w_state_nxt  = ST_RUN;
            w_rem_nxt    = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hz) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        w_rem_nxt   = STALL_EXTRA;
                        w_state_nxt = (STALL_EXTRA != 4'd0) ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    // Hazard input is ignored here; the load is already
                    // counted down by rem.
                    PC_WRITE    = 1'b0;
                    IF_ID_WRITE = 1'b0;
                    ID_EX_FLUSH = 1'b1;
                    w_rem_nxt   = r_rem - 4'd1;
                    if (r_rem == 4'd1)
                        w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_rem_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign STATE = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_inc;

    assign w_stall_inc = !PC_WRITE && !RST;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (w_stall_inc),
        .o_cnt (STALL_CNT)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (BRANCH_TAKEN),
        .o_cnt (FLUSH_CNT)
    );
`endif

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// tb_if_hazard_ctrl
//   Directed bench for if_hazard_ctrl. Two instances share the inputs:
//   u1 with LOAD_STALL=1 and u3 with LOAD_STALL=3 (CNT_W=4). Inputs change
//   1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_if_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] ID_RS, ID_RT, EX_RT;
    logic       ID_USES_RT, EX_MEM_READ, BRANCH_TAKEN;

    logic pcw1, ifw1, iff1, idf1, exf1, src1, st1;
    logic pcw3, ifw3, iff3, idf3, exf3, src3, st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] scnt1, fcnt1;
    logic [3:0]  scnt3, fcnt3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    if_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) u1 (
        .CLK(CLK), .RST(RST), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RT(ID_USES_RT), .EX_MEM_READ(EX_MEM_READ), .EX_RT(EX_RT),
        .BRANCH_TAKEN(BRANCH_TAKEN), .PC_WRITE(pcw1), .IF_ID_WRITE(ifw1),
        .IF_ID_FLUSH(iff1), .ID_EX_FLUSH(idf1), .EX_MEM_FLUSH(exf1),
        .PC_SRC(src1), .STATE(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(scnt1), .FLUSH_CNT(fcnt1)
`endif
    );

    if_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(4)) u3 (
        .CLK(CLK), .RST(RST), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RT(ID_USES_RT), .EX_MEM_READ(EX_MEM_READ), .EX_RT(EX_RT),
        .BRANCH_TAKEN(BRANCH_TAKEN), .PC_WRITE(pcw3), .IF_ID_WRITE(ifw3),
        .IF_ID_FLUSH(iff3), .ID_EX_FLUSH(idf3), .EX_MEM_FLUSH(exf3),
        .PC_SRC(src3), .STATE(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(scnt3), .FLUSH_CNT(fcnt3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic rd, input logic [4:0] ert, input logic br);
        ID_RS = rs; ID_RT = rt; ID_USES_RT = uses;
        EX_MEM_READ = rd; EX_RT = ert; BRANCH_TAKEN = br;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    // Flags packed as {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, PC_SRC, STATE}
    function automatic logic [6:0] o3();
        return {pcw3, ifw3, iff3, idf3, exf3, src3, st3};
    endfunction
    function automatic logic [6:0] o1();
        return {pcw1, ifw1, iff1, idf1, exf1, src1, st1};
    endfunction

    initial begin
        RST = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        @(negedge CLK);
        chk("reset_outputs", 32'(o3()), 32'b0011100);
        step();
        RST = 1'b0;

        // First cycle after reset: plain RUN
        @(negedge CLK);
        chk("run_after_reset", 32'(o3()), 32'b1100000);
        step();

        // Load-use via rs, LOAD_STALL=1: single bubble cycle
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        @(negedge CLK);
        chk("ls1_rs_stall", 32'(o1()), 32'b0001000);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("ls1_back_run", 32'(o1()), 32'b1100000);
        step();

        // Multi-cycle stall via rt, LOAD_STALL=3; hazard held throughout
        do_reset();
        drive(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0);
        @(negedge CLK);
        chk("ls3_cyc1", 32'(o3()), 32'b0001000);
        step();
        @(negedge CLK);
        chk("ls3_cyc2", 32'(o3()), 32'b0001001);
        step();
        @(negedge CLK);
        chk("ls3_cyc3", 32'(o3()), 32'b0001001);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("ls3_cyc4_run", 32'(o3()), 32'b1100000);
        step();

        // Same rt match but rt not a source: no stall
        drive(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0);
        @(negedge CLK);
        chk("rt_unused_nostall", 32'(o3()), 32'b1100000);
        step();
        @(negedge CLK);
        chk("rt_unused_state", 32'(st3), 32'd0);
        step();

        // Register zero never stalls
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        @(negedge CLK);
        chk("reg0_u1", 32'(o1()), 32'b1100000);
        chk("reg0_u3", 32'(o3()), 32'b1100000);
        step();

        // Branch in 2nd stall cycle aborts the stall
        drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        @(negedge CLK);
        chk("br_abort_cyc1", 32'(o3()), 32'b0001000);
        step();
        BRANCH_TAKEN = 1'b1;
        @(negedge CLK);
        chk("br_abort_cyc2", 32'(o3()), 32'b1011111);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("br_abort_after", 32'(o3()), 32'b1100000);
        step();

        // Hazard and branch together in RUN: branch wins, no stall
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
        @(negedge CLK);
        chk("hz_br_same_u3", 32'(o3()), 32'b1011110);
        chk("hz_br_same_u1", 32'(o1()), 32'b1011110);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("hz_br_after", 32'(o3()), 32'b1100000);
        step();

        // Async reset mid-stall
        drive(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("pre_async_rst_stall", 32'(st3), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(o3()), 32'b0011100);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("async_rst_release", 32'(o3()), 32'b1100000);
        step();

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        @(negedge CLK);
        chk("cnt_reset_stall", 32'(scnt3), 32'd0);
        chk("cnt_reset_flush", 32'(fcnt3), 32'd0);
        // Continuous hazard: PC_WRITE=0 every cycle on u3
        drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 5; i++) step();
        @(negedge CLK);
        chk("cnt_stall_5", 32'(scnt3), 32'd5);
        chk("cnt_stall_5_u1", 32'(scnt1), 32'd5);
        for (int i = 0; i < 15; i++) step();
        @(negedge CLK);
        chk("cnt_stall_sat", 32'(scnt3), 32'd15);
        chk("cnt_stall_20_u1", 32'(scnt1), 32'd20);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        step();
        BRANCH_TAKEN = 1'b0;
        step();
        BRANCH_TAKEN = 1'b1;
        step();
        BRANCH_TAKEN = 1'b0;
        @(negedge CLK);
        chk("cnt_flush_2", 32'(fcnt3), 32'd2);
        chk("cnt_stall_hold", 32'(scnt3), 32'd15);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
